// File: rtl/hazard_stall_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit_pkg
//
// Shared definitions for the pipeline hazard unit:
//   - REG_FILE_ADDR_LEN  : default register address width (REG_ADDR_W)
//   - MUL_CYCLES_DEFAULT : default number of cycles a MUL occupies EXE
//   - CNT_W_DEFAULT      : default stall counter width
//   - mul_state_t        : multiply FSM state encodings MUL_ST_IDLE/MUL_ST_BUSY
// ----------------------------------------------------------------------------
package hazard_stall_unit_pkg;

    localparam int REG_FILE_ADDR_LEN  = 5;
    localparam int MUL_CYCLES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT      = 16;

    typedef enum logic {
        MUL_ST_IDLE = 1'b0,
        MUL_ST_BUSY = 1'b1
    } mul_state_t;

endpackage : hazard_stall_unit_pkg

// File: rtl/mul_stall_fsm.sv
// ----------------------------------------------------------------------------
// mul_stall_fsm
//
// Holds a multi-cycle MUL in the EXE stage. When a MUL is seen in EXE while
// idle, mul_hold is raised for MUL_CYCLES-1 cycles; it drops on the last
// cycle so the MUL leaves EXE on the following edge. A MUL still present
// afterwards is treated as a new one and gets its own full count.
//
// Parameters:
//   MUL_CYCLES  cycles a MUL occupies EXE (>= 1; 1 means never hold)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   exe_is_mul  EXE instruction is a MUL
//   mul_hold    hold ID/EXE and bubble EX/MEM this cycle
// ----------------------------------------------------------------------------
module mul_stall_fsm
    import hazard_stall_unit_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic exe_is_mul,
    output logic mul_hold
);

    generate
        if (MUL_CYCLES > 1) begin : g_fsm
            // Counter only ever holds values up to MUL_CYCLES-1.
            localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

            mul_state_t    state_reg;
            mul_state_t    state_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          hold_next;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= MUL_ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                hold_next  = 1'b0;
                case (state_reg)
                    MUL_ST_IDLE: begin
                        if (exe_is_mul) begin
                            hold_next  = 1'b1;
                            cnt_next   = CW'(MUL_CYCLES - 1);
                            state_next = MUL_ST_BUSY;
                        end
                    end
                    MUL_ST_BUSY: begin
                        if (cnt_reg > CW'(1)) begin
                            hold_next = 1'b1;
                            cnt_next  = cnt_reg - CW'(1);
                        end else begin
                            // Last EXE cycle of the MUL: release the hold so
                            // the pipeline advances on this edge.
                            hold_next  = 1'b0;
                            cnt_next   = '0;
                            state_next = MUL_ST_IDLE;
                        end
                    end
                    default: begin
                        state_next = MUL_ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign mul_hold = hold_next;
        end else begin : g_no_fsm
            // Single-cycle MUL: nothing to hold.
            logic unused_mul_in;
            assign unused_mul_in = ^{clk, rst_n, exe_is_mul};
            assign mul_hold      = 1'b0;
        end
    endgenerate

endmodule : mul_stall_fsm

// File: rtl/hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard unit beside the ID stage. Detects RAW hazards between the
// ID sources and the EXE/MEM destinations, holds a multi-cycle MUL in EXE,
// drives freeze/flush/bubble controls and counts stall cycles.
//
// Build option:
//   FORWARDING_EN  defined   : only load-use against EXE stalls.
//                  undefined : any writer in EXE or MEM that matches stalls.
//
// Parameters:
//   MUL_CYCLES  cycles a MUL occupies EXE (>= 1)
//   REG_ADDR_W  register address width
//   CNT_W       stall counter width
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   src1, src2, two_src        ID sources; src2 only valid with two_src
//   exe_dest, exe_wb_en        EXE destination / writes back
//   exe_mem_r_en, exe_is_mul   EXE is a load / is a MUL
//   mem_dest, mem_wb_en        MEM destination / writes back
//   branch_taken               branch/jump resolved taken in ID
//   hazard_detected            bubble into ID/EXE
//   pc_freeze, if_id_freeze    hold PC and IF/ID
//   id_exe_hold                hold ID/EXE (MUL stays in EXE)
//   exe_mem_bubble             bubble into EX/MEM
//   if_id_flush                squash IF/ID
//   stall_count                saturating count of frozen cycles
// ----------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic                  exe_is_mul,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  branch_taken,
    output logic                  hazard_detected,
    output logic                  pc_freeze,
    output logic                  if_id_freeze,
    output logic                  id_exe_hold,
    output logic                  exe_mem_bubble,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_count
);

    // Stage 0 = EXE, stage 1 = MEM.
    logic [REG_ADDR_W-1:0] stage_dest [2];
    logic [1:0]            stage_match;
    logic                  data_hz;
    logic                  mul_hold;
    logic                  freeze;
    logic [CNT_W-1:0]      count_reg;

    assign stage_dest[0] = exe_dest;
    assign stage_dest[1] = mem_dest;

    // Register 0 is hard-wired, so it can never carry a dependency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            assign stage_match[gi] = (stage_dest[gi] != '0) &&
                                     ((stage_dest[gi] == src1) ||
                                      (two_src && (stage_dest[gi] == src2)));
        end
    endgenerate

`ifdef FORWARDING_EN
    // Everything except a load result in EXE can be forwarded.
    assign data_hz = exe_mem_r_en & stage_match[0];

    logic unused_fwd;
    assign unused_fwd = ^{exe_wb_en, mem_wb_en, stage_match[1]};
`else
    assign data_hz = (exe_wb_en & stage_match[0]) | (mem_wb_en & stage_match[1]);

    logic unused_nofwd;
    assign unused_nofwd = exe_mem_r_en;
`endif

    mul_stall_fsm #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_stall_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .exe_is_mul (exe_is_mul),
        .mul_hold   (mul_hold)
    );

    assign freeze = data_hz | mul_hold;

    // Stall counter saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (freeze && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // All outputs are gated low while reset is asserted. While ID/EXE is held
    // by a MUL no bubble is inserted, and a stalled branch has not resolved
    // so it must not flush.
    assign id_exe_hold     = rst_n & mul_hold;
    assign exe_mem_bubble  = rst_n & mul_hold;
    assign pc_freeze       = rst_n & freeze;
    assign if_id_freeze    = rst_n & freeze;
    assign hazard_detected = rst_n & data_hz & ~mul_hold;
    assign if_id_flush     = rst_n & branch_taken & ~freeze;
    assign stall_count     = rst_n ? count_reg : '0;

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit (MUL_CYCLES=4, REG_ADDR_W=5, CNT_W=4
// so saturation is reachable). A reference model derived from the hazard
// rules is compared on every falling edge; hand-computed literal expectations
// for selected cycles are checked alongside it.
// ----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int MC = 4;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] src1, src2, exe_dest, mem_dest;
    logic          two_src, exe_wb_en, exe_mem_r_en, exe_is_mul, mem_wb_en, branch_taken;
    logic          hazard_detected, pc_freeze, if_id_freeze, id_exe_hold;
    logic          exe_mem_bubble, if_id_flush;
    logic [CW-1:0] stall_count;

    hazard_stall_unit #(
        .MUL_CYCLES (MC),
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src1            (src1),
        .src2            (src2),
        .two_src         (two_src),
        .exe_dest        (exe_dest),
        .exe_wb_en       (exe_wb_en),
        .exe_mem_r_en    (exe_mem_r_en),
        .exe_is_mul      (exe_is_mul),
        .mem_dest        (mem_dest),
        .mem_wb_en       (mem_wb_en),
        .branch_taken    (branch_taken),
        .hazard_detected (hazard_detected),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .id_exe_hold     (id_exe_hold),
        .exe_mem_bubble  (exe_mem_bubble),
        .if_id_flush     (if_id_flush),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // mul_age: how many cycles the MUL currently in EXE has already spent
    // there (0 = no MUL in progress). A MUL blocks EXE for its first
    // MC-1 cycles.
    int            mul_age;
    int            model_cnt;

    function automatic bit reads(input logic [AW-1:0] d);
        return (d != 0) && ((d == src1) || (two_src && (d == src2)));
    endfunction

    function automatic bit model_dhz();
`ifdef FORWARDING_EN
        return exe_mem_r_en && reads(exe_dest);
`else
        return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
`endif
    endfunction

    function automatic bit model_hold();
        if (mul_age > 0) return (mul_age < MC - 1);
        return exe_is_mul && (MC > 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_age   <= 0;
            model_cnt <= 0;
        end else begin
            if ((model_dhz() || model_hold()) && model_cnt < (1 << CW) - 1)
                model_cnt <= model_cnt + 1;
            if (mul_age > 0)
                mul_age <= (mul_age + 1 == MC) ? 0 : mul_age + 1;
            else if (model_hold())
                mul_age <= 1;
        end
    end

    // ---------------- literal pins ----------------
    bit            pin_en = 1'b0;
    string         pin_name;
    bit            pin_hd, pin_pc, pin_hold, pin_flush;
    int            pin_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit e_hd, e_pc, e_hold, e_flush;
        int e_cnt;
        if (!rst_n) begin
            e_hd = 0; e_pc = 0; e_hold = 0; e_flush = 0; e_cnt = 0;
        end else begin
            e_hold  = model_hold();
            e_pc    = model_dhz() || e_hold;
            e_hd    = model_dhz() && !e_hold;
            e_flush = branch_taken && !e_pc;
            e_cnt   = model_cnt;
        end
        chk("model.hazard_detected", int'(hazard_detected), int'(e_hd));
        chk("model.pc_freeze",       int'(pc_freeze),       int'(e_pc));
        chk("model.if_id_freeze",    int'(if_id_freeze),    int'(e_pc));
        chk("model.id_exe_hold",     int'(id_exe_hold),     int'(e_hold));
        chk("model.exe_mem_bubble",  int'(exe_mem_bubble),  int'(e_hold));
        chk("model.if_id_flush",     int'(if_id_flush),     int'(e_flush));
        chk("model.stall_count",     int'(stall_count),     e_cnt);
        if (pin_en) begin
            chk({pin_name, ".hazard_detected"}, int'(hazard_detected), int'(pin_hd));
            chk({pin_name, ".pc_freeze"},       int'(pc_freeze),       int'(pin_pc));
            chk({pin_name, ".id_exe_hold"},     int'(id_exe_hold),     int'(pin_hold));
            chk({pin_name, ".if_id_flush"},     int'(if_id_flush),     int'(pin_flush));
            chk({pin_name, ".stall_count"},     int'(stall_count),     pin_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin literal expectations for the current cycle, then advance.
    task automatic step(input string nm, input bit hd, input bit pc,
                        input bit hold, input bit flush, input int cnt);
        pin_name  = nm;
        pin_hd    = hd;
        pin_pc    = pc;
        pin_hold  = hold;
        pin_flush = flush;
        pin_cnt   = cnt;
        pin_en    = 1'b1;
        tick();
        pin_en    = 1'b0;
    endtask

    task automatic clear_inputs();
        src1 = '0; src2 = '0; two_src = 0;
        exe_dest = '0; exe_wb_en = 0; exe_mem_r_en = 0; exe_is_mul = 0;
        mem_dest = '0; mem_wb_en = 0; branch_taken = 0;
    endtask

    task automatic load_use(input logic [AW-1:0] r);
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = r; src1 = r;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();

        // Reset: outputs forced low even with hazards presented.
        step("reset_idle", 0, 0, 0, 0, 0);
        exe_is_mul = 1; load_use(5'd3); branch_taken = 1;
        step("reset_gated", 0, 0, 0, 0, 0);
        clear_inputs();
        rst_n = 1'b1;

        // Load-use: one stall cycle, counter 0 -> 1.
        load_use(5'd3);
        step("load_use", 1, 1, 0, 0, 0);
        clear_inputs();
        step("load_use_after", 0, 0, 0, 0, 1);
        load_use(5'd0);
        step("load_r0", 0, 0, 0, 0, 1);

        // Two-source match on src2.
        clear_inputs();
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5'd5; src1 = 5'd1; src2 = 5'd5;
        two_src = 1;
        step("two_src_1", 1, 1, 0, 0, 1);
        two_src = 0;
        step("two_src_0", 0, 0, 0, 0, 2);

        // Branch vs stall.
        clear_inputs();
        branch_taken = 1;
        step("branch_free", 0, 0, 0, 1, 2);
        load_use(5'd3);
        step("branch_stalled", 1, 1, 0, 0, 2);

        // MUL hold, back-to-back; second MUL overlaps a data hazard.
        clear_inputs();
        exe_is_mul = 1;
        step("mul1_c0", 0, 1, 1, 0, 3);
        step("mul1_c1", 0, 1, 1, 0, 4);
        step("mul1_c2", 0, 1, 1, 0, 5);
        step("mul1_c3", 0, 0, 0, 0, 6);
        load_use(5'd4);
        step("mul2_c0", 0, 1, 1, 0, 6);
        step("mul2_c1", 0, 1, 1, 0, 7);
        step("mul2_c2", 0, 1, 1, 0, 8);
        step("mul2_c3", 1, 1, 0, 0, 9);

        // Reset in BUSY with cnt=2, then a full restart.
        clear_inputs();
        exe_is_mul = 1;
        step("mul3_c0", 0, 1, 1, 0, 10);
        step("mul3_c1", 0, 1, 1, 0, 11);
        rst_n = 1'b0;
        step("mul3_reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("mul4_c0", 0, 1, 1, 0, 0);
        step("mul4_c1", 0, 1, 1, 0, 1);
        step("mul4_c2", 0, 1, 1, 0, 2);
        step("mul4_c3", 0, 0, 0, 0, 3);
        exe_is_mul = 0;
        step("mul4_done", 0, 0, 0, 0, 3);

        // MEM-stage dependency: stalls only without forwarding.
        mem_wb_en = 1; mem_dest = 5'd7; src1 = 5'd7;
`ifdef FORWARDING_EN
        step("mem_dep", 0, 0, 0, 0, 3);
`else
        step("mem_dep", 1, 1, 0, 0, 3);
`endif

        // Saturation of the stall counter.
        clear_inputs();
        load_use(5'd9);
        for (int i = 0; i < 20; i++) tick();
        step("sat_a", 1, 1, 0, 0, 15);
        step("sat_b", 1, 1, 0, 0, 15);
        clear_inputs();
        step("sat_idle", 0, 0, 0, 0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_stall_unit
